sdrc_app_arb: RTL and testbench

- Round-robin arbiter that shares one sdrc_core application request port between NREQ independent requesters, e.g. several wb2sdrc-style bridges or DMA engines.
- Owns the request handshake.
- Tracks which requester owns each accepted but unfinished transfer in two in-order owner FIFOs, one for reads and one for writes.
- Uses those FIFOs to steer write-data requests and read-return beats to the correct requester.
- Sits on the sdram_clk domain between the requester bridges and sdrc_core.

---
 rtl/sdrc_app_arb.sv | 252 +++++++++++++++++++++++++
 tb/tb_sdrc_app_arb.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdrc_app_arb.sv
// -----------------------------------------------------------------------------
// sdrc_app_arb
//
// Round-robin arbiter that shares one sdrc_core application request port
// between NREQ requesters. It runs the request handshake toward the core. It
// records the owner of every accepted but unfinished transfer in two in-order
// owner FIFOs, one for reads and one for writes. The FIFO heads steer
// write-data requests and read-return beats back to the correct requester.
//
// Ports:
//   sdram_clk, sdram_rst      clock, synchronous active-high reset
//   sdr_init_done             gates all new requests while the SDRAM initialises
//   rq_req/addr/len/wr_n      per-requester request (requester i in slice i)
//   rq_ack                    one-cycle accept pulse to the granted requester
//   rq_wr_data/wr_en_n        per-requester write data / active-low byte enables
//   rq_wr_next                per-requester write-data advance strobe
//   rq_rd_valid/last_rd       per-requester read beat valid / last beat
//   rq_rd_data                read data, broadcast to all requesters
//   app_req*                  registered request toward sdrc_core
//   app_wr_next_req/last_wr   core write-beat consume / last write beat
//   app_wr_data/wr_en_n       write data and byte enables toward the core
//   app_rd_valid/last_rd/data read return from the core
//   err_orphan                sticky: a core beat arrived with no owner recorded
//
// ODEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module sdrc_app_arb #(
  parameter int NREQ   = 2,
  parameter int APP_AW = 26,
  parameter int bl     = 9,
  parameter int dw     = 32,
  parameter int ODEPTH = 4
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_rst,
  input  logic                     sdr_init_done,

  input  logic [NREQ-1:0]          rq_req,
  input  logic [NREQ*APP_AW-1:0]   rq_addr,
  input  logic [NREQ*bl-1:0]       rq_len,
  input  logic [NREQ-1:0]          rq_wr_n,
  output logic [NREQ-1:0]          rq_ack,
  input  logic [NREQ*dw-1:0]       rq_wr_data,
  input  logic [NREQ*(dw/8)-1:0]   rq_wr_en_n,
  output logic [NREQ-1:0]          rq_wr_next,
  output logic [NREQ-1:0]          rq_rd_valid,
  output logic [NREQ-1:0]          rq_last_rd,
  output logic [dw-1:0]            rq_rd_data,

  output logic                     app_req,
  output logic [APP_AW-1:0]        app_req_addr,
  output logic [bl-1:0]            app_req_len,
  output logic                     app_req_wr_n,
  input  logic                     app_req_ack,
  input  logic                     app_wr_next_req,
  input  logic                     app_last_wr,
  output logic [dw-1:0]            app_wr_data,
  output logic [dw/8-1:0]          app_wr_en_n,
  input  logic                     app_rd_valid,
  input  logic                     app_last_rd,
  input  logic [dw-1:0]            app_rd_data,

  output logic                     err_orphan
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;  // requester index width
  localparam int AW = $clog2(ODEPTH);                 // FIFO address width
  localparam int PW = AW + 1;                         // pointer width (extra wrap bit)
  localparam int BW = dw / 8;
  localparam int RD = 0;                              // owner FIFO 0 tracks reads
  localparam int WR = 1;                              // owner FIFO 1 tracks writes

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state_reg;
  logic [IW-1:0]   gnt_reg;
  // Index holding highest priority in the next arbitration round, i.e.
  // last_grant+1. Reset to 0 so requester 0 is served first after reset.
  logic [IW-1:0]   rr_ptr_reg;
  logic            app_req_reg;
  logic [APP_AW-1:0] app_req_addr_reg;
  logic [bl-1:0]   app_req_len_reg;
  logic            app_req_wr_n_reg;
  logic            err_orphan_reg;

  // Per-requester views of the flattened input buses.
  logic [APP_AW-1:0] addr_arr    [NREQ];
  logic [bl-1:0]     len_arr     [NREQ];
  logic [dw-1:0]     wr_data_arr [NREQ];
  logic [BW-1:0]     wr_en_n_arr [NREQ];
  logic [NREQ-1:0]   eligible;

  // Owner FIFO status, indexed by RD / WR.
  logic [1:0]          fifo_push;
  logic [1:0]          fifo_pop;
  logic [1:0]          fifo_full;
  logic [1:0]          fifo_empty;
  logic [1:0][IW-1:0]  fifo_head;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            accept;
  logic            orphan;

  // ---------------------------------------------------------------------------
  // Per-requester slicing and eligibility. A requester is blocked only by
  // the owner FIFO matching its own direction.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign addr_arr[gi]    = rq_addr[gi*APP_AW +: APP_AW];
    assign len_arr[gi]     = rq_len[gi*bl +: bl];
    assign wr_data_arr[gi] = rq_wr_data[gi*dw +: dw];
    assign wr_en_n_arr[gi] = rq_wr_en_n[gi*BW +: BW];
    assign eligible[gi]    = rq_req[gi] & sdr_init_done &
                             ~(rq_wr_n[gi] ? fifo_full[RD] : fifo_full[WR]);
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan from rr_ptr_reg upward (mod NREQ). The loop runs
  // from the farthest offset down so the nearest eligible index wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [IW-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr_reg) + k) % NREQ);
      if (eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign accept = (state_reg == REQ) && app_req_ack;

  assign fifo_push[RD] = accept &  app_req_wr_n_reg;
  assign fifo_push[WR] = accept & ~app_req_wr_n_reg;
  assign fifo_pop[RD]  = app_rd_valid    & app_last_rd & ~fifo_empty[RD];
  assign fifo_pop[WR]  = app_wr_next_req & app_last_wr & ~fifo_empty[WR];

  // A core beat with nobody on record to receive it is dropped and flagged.
  assign orphan = (app_rd_valid & fifo_empty[RD]) | (app_wr_next_req & fifo_empty[WR]);

  // ---------------------------------------------------------------------------
  // Owner FIFOs. Pointers carry one extra wrap bit so full and empty can be
  // told apart when the low bits match. Push and pop in the same cycle both
  // take effect and leave occupancy unchanged.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [IW-1:0] mem [ODEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;

    always_ff @(posedge sdram_clk) begin
      if (sdram_rst) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge sdram_clk) begin
      if (fifo_push[gi]) mem[wr_ptr_reg[AW-1:0]] <= gnt_reg;
    end

    assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                            (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign fifo_head[gi]  = mem[rd_ptr_reg[AW-1:0]];
  end

  // ---------------------------------------------------------------------------
  // Request FSM with registered app_* outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_reg        <= IDLE;
      gnt_reg          <= '0;
      rr_ptr_reg       <= '0;
      app_req_reg      <= 1'b0;
      app_req_addr_reg <= '0;
      app_req_len_reg  <= '0;
      app_req_wr_n_reg <= 1'b1;
      err_orphan_reg   <= 1'b0;
    end else begin
      if (orphan) err_orphan_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            app_req_reg      <= 1'b1;
            app_req_addr_reg <= addr_arr[pick_idx];
            app_req_len_reg  <= len_arr[pick_idx];
            app_req_wr_n_reg <= rq_wr_n[pick_idx];
            gnt_reg          <= pick_idx;
            state_reg        <= REQ;
          end
        end
        REQ: begin
          // Fields stay frozen until the core accepts, even if the requester
          // withdraws rq_req in the meantime.
          if (app_req_ack) begin
            app_req_reg <= 1'b0;
            rr_ptr_reg  <= (gnt_reg == IW'(NREQ - 1)) ? '0 : gnt_reg + 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign app_req      = app_req_reg;
  assign app_req_addr = app_req_addr_reg;
  assign app_req_len  = app_req_len_reg;
  assign app_req_wr_n = app_req_wr_n_reg;
  assign err_orphan   = err_orphan_reg;

  // Read data is a straight wire to every requester; only valid is steered.
  assign rq_rd_data = app_rd_data;

  // ---------------------------------------------------------------------------
  // Steering toward requesters. Held quiet during reset so no requester sees
  // a stale ack or beat while ownership is being discarded.
  // ---------------------------------------------------------------------------
  always_comb begin
    rq_ack      = '0;
    rq_wr_next  = '0;
    rq_rd_valid = '0;
    rq_last_rd  = '0;
    app_wr_data = '0;
    app_wr_en_n = '1;
    if (!sdram_rst) begin
      if (accept) rq_ack[gnt_reg] = 1'b1;
      if (!fifo_empty[WR]) begin
        app_wr_data                = wr_data_arr[fifo_head[WR]];
        app_wr_en_n                = wr_en_n_arr[fifo_head[WR]];
        rq_wr_next[fifo_head[WR]]  = app_wr_next_req;
      end
      if (!fifo_empty[RD]) begin
        rq_rd_valid[fifo_head[RD]] = app_rd_valid;
        rq_last_rd[fifo_head[RD]]  = app_last_rd;
      end
    end
  end

endmodule

// File: tb/tb_sdrc_app_arb.sv
// -----------------------------------------------------------------------------
// tb_sdrc_app_arb
//
// Self-checking bench for sdrc_app_arb with two requesters. Expected grants,
// write beats and read beats are queued as stimulus is driven and compared
// when the arbiter produces them.
// -----------------------------------------------------------------------------
module tb_sdrc_app_arb;

  localparam int NREQ   = 2;
  localparam int APP_AW = 26;
  localparam int BL     = 9;
  localparam int DW     = 32;
  localparam int ODEPTH = 4;

  logic                   sdram_clk;
  logic                   sdram_rst;
  logic                   sdr_init_done;
  logic [NREQ-1:0]        rq_req;
  logic [NREQ*APP_AW-1:0] rq_addr;
  logic [NREQ*BL-1:0]     rq_len;
  logic [NREQ-1:0]        rq_wr_n;
  logic [NREQ-1:0]        rq_ack;
  logic [NREQ*DW-1:0]     rq_wr_data;
  logic [NREQ*DW/8-1:0]   rq_wr_en_n;
  logic [NREQ-1:0]        rq_wr_next;
  logic [NREQ-1:0]        rq_rd_valid;
  logic [NREQ-1:0]        rq_last_rd;
  logic [DW-1:0]          rq_rd_data;
  logic                   app_req;
  logic [APP_AW-1:0]      app_req_addr;
  logic [BL-1:0]          app_req_len;
  logic                   app_req_wr_n;
  logic                   app_req_ack;
  logic                   app_wr_next_req;
  logic                   app_last_wr;
  logic [DW-1:0]          app_wr_data;
  logic [DW/8-1:0]        app_wr_en_n;
  logic                   app_rd_valid;
  logic                   app_last_rd;
  logic [DW-1:0]          app_rd_data;
  logic                   err_orphan;

  sdrc_app_arb #(
    .NREQ(NREQ), .APP_AW(APP_AW), .bl(BL), .dw(DW), .ODEPTH(ODEPTH)
  ) dut (
    .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .sdr_init_done(sdr_init_done),
    .rq_req(rq_req), .rq_addr(rq_addr), .rq_len(rq_len), .rq_wr_n(rq_wr_n),
    .rq_ack(rq_ack), .rq_wr_data(rq_wr_data), .rq_wr_en_n(rq_wr_en_n),
    .rq_wr_next(rq_wr_next), .rq_rd_valid(rq_rd_valid), .rq_last_rd(rq_last_rd),
    .rq_rd_data(rq_rd_data), .app_req(app_req), .app_req_addr(app_req_addr),
    .app_req_len(app_req_len), .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_next_req(app_wr_next_req), .app_last_wr(app_last_wr),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n), .app_rd_valid(app_rd_valid),
    .app_last_rd(app_last_rd), .app_rd_data(app_rd_data), .err_orphan(err_orphan)
  );

  initial sdram_clk = 1'b0;
  always #5 sdram_clk = ~sdram_clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]        idx;
    logic [APP_AW-1:0] addr;
    logic [BL-1:0]     len;
    logic              wr_n;
  } grant_t;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] last;
  } rbeat_t;

  grant_t        gq[$];
  logic [DW-1:0] wq[$];
  rbeat_t        rq[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Queue the grant a requester should receive, taken from its current request.
  task automatic expect_grant(input int idx);
    grant_t e;
    e.idx  = 2'(idx);
    e.addr = rq_addr[idx*APP_AW +: APP_AW];
    e.len  = rq_len[idx*BL +: BL];
    e.wr_n = rq_wr_n[idx];
    gq.push_back(e);
  endtask

  // Core model: wait for app_req, check it against the next queued grant,
  // ack it for one cycle, optionally let the requester withdraw afterwards.
  task automatic serve(input bit drop);
    int n;
    grant_t e;
    logic [NREQ-1:0] m;
    n = 0;
    while (app_req !== 1'b1 && n < 20) begin
      @(negedge sdram_clk);
      n++;
    end
    if (app_req !== 1'b1) begin
      check_val("grant_timeout", 64'(app_req), 64'd1);
      return;
    end
    if (gq.size() == 0) begin
      check_val("grant_unexpected", 64'd1, 64'd0);
      return;
    end
    e = gq.pop_front();
    check_val("app_req_addr", 64'(app_req_addr), 64'(e.addr));
    check_val("app_req_len",  64'(app_req_len),  64'(e.len));
    check_val("app_req_wr_n", 64'(app_req_wr_n), 64'(e.wr_n));
    app_req_ack = 1'b1;
    #1;
    m = 2'b01 << e.idx;
    check_val("rq_ack", 64'(rq_ack), 64'(m));
    $display("grant: requester %0d addr=%0h len=%0d wr_n=%0b", e.idx, app_req_addr, app_req_len, app_req_wr_n);
    @(negedge sdram_clk);
    app_req_ack = 1'b0;
    if (drop) rq_req[e.idx] = 1'b0;
    check_val("app_req_drop", 64'(app_req), 64'd0);
  endtask

  task automatic do_reset;
    @(negedge sdram_clk);
    sdram_rst = 1'b1;
    @(negedge sdram_clk);
    sdram_rst = 1'b0;
    gq.delete();
    wq.delete();
    rq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rbeat_t rb;
    logic [DW-1:0] wexp;
    int n;

    sdram_rst       = 1'b0;
    sdr_init_done   = 1'b0;
    rq_req          = 2'b11;
    rq_wr_n         = 2'b11;
    rq_addr         = {26'h000_2000, 26'h000_1000};
    rq_len          = {9'd2, 9'd4};
    rq_wr_data      = {32'hDEAD_BEEF, 32'hA500_0000};
    rq_wr_en_n      = {4'b1010, 4'b0101};
    app_req_ack     = 1'b0;
    app_wr_next_req = 1'b0;
    app_last_wr     = 1'b0;
    app_rd_valid    = 1'b0;
    app_last_rd     = 1'b0;
    app_rd_data     = '0;

    // ---- Reset state, init gating, first-request latency, alternation ----
    do_reset();
    check_val("rst_app_req",      64'(app_req),      64'd0);
    check_val("rst_app_req_addr", 64'(app_req_addr), 64'd0);
    check_val("rst_app_req_len",  64'(app_req_len),  64'd0);
    check_val("rst_app_req_wr_n", 64'(app_req_wr_n), 64'd1);
    check_val("rst_rq_ack",       64'(rq_ack),       64'd0);
    check_val("rst_rq_wr_next",   64'(rq_wr_next),   64'd0);
    check_val("rst_rq_rd_valid",  64'(rq_rd_valid),  64'd0);
    check_val("rst_err_orphan",   64'(err_orphan),   64'd0);
    check_val("rst_app_wr_en_n",  64'(app_wr_en_n),  64'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge sdram_clk);
      check_val("no_init_no_req", 64'(app_req), 64'd0);
    end
    sdr_init_done = 1'b1;
    expect_grant(0);
    @(negedge sdram_clk);
    check_val("init_latency", 64'(app_req), 64'd1);
    serve(1'b0);
    expect_grant(1); serve(1'b0);
    expect_grant(0); serve(1'b0);
    expect_grant(1); serve(1'b0);

    // ---- Write from requester 0 (len 4) and read to requester 1 (len 2) ----
    rq_req = 2'b00;
    do_reset();
    rq_wr_n = 2'b10;
    rq_req  = 2'b11;
    expect_grant(0);
    expect_grant(1);
    serve(1'b1);
    serve(1'b1);
    for (int b = 0; b < 4; b++) begin
      rq_wr_data[31:0] = 32'hA500_0000 + 32'(b);
      wq.push_back(rq_wr_data[31:0]);
      app_wr_next_req = 1'b1;
      app_last_wr     = (b == 3);
      #1;
      wexp = wq.pop_front();
      check_val("wr_data",    64'(app_wr_data), 64'(wexp));
      check_val("wr_en_n",    64'(app_wr_en_n), 64'b0101);
      check_val("rq_wr_next", 64'(rq_wr_next),  64'b01);
      $display("wr beat %0d: data=%0h next=%b", b, app_wr_data, rq_wr_next);
      @(negedge sdram_clk);
    end
    app_wr_next_req = 1'b0;
    app_last_wr     = 1'b0;
    #1;
    check_val("wr_empty_en_n", 64'(app_wr_en_n), 64'hF);
    check_val("wr_empty_data", 64'(app_wr_data), 64'd0);
    for (int b = 0; b < 2; b++) begin
      app_rd_data  = 32'hC0DE_0000 + 32'(b);
      app_rd_valid = 1'b1;
      app_last_rd  = (b == 1);
      rb.data  = app_rd_data;
      rb.valid = 2'b10;
      rb.last  = (b == 1) ? 2'b10 : 2'b00;
      rq.push_back(rb);
      #1;
      rb = rq.pop_front();
      check_val("rq_rd_valid", 64'(rq_rd_valid), 64'(rb.valid));
      check_val("rq_last_rd",  64'(rq_last_rd),  64'(rb.last));
      check_val("rq_rd_data",  64'(rq_rd_data),  64'(rb.data));
      $display("rd beat %0d: data=%0h valid=%b last=%b", b, rq_rd_data, rq_rd_valid, rq_last_rd);
      @(negedge sdram_clk);
    end
    app_rd_valid = 1'b0;
    app_last_rd  = 1'b0;
    @(negedge sdram_clk);
    check_val("no_orphan_after_traffic", 64'(err_orphan), 64'd0);

    // ---- Read FIFO full blocks reads only; one burst re-enables ----
    rq_req = 2'b00;
    do_reset();
    rq_wr_n = 2'b10;
    rq_req  = 2'b10;
    for (int i = 0; i < ODEPTH; i++) begin
      expect_grant(1);
      serve(1'b0);
    end
    rq_req[0] = 1'b1;
    expect_grant(0);
    serve(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge sdram_clk);
      check_val("rd_full_held_off", 64'(app_req), 64'd0);
    end
    app_rd_valid = 1'b1;
    app_last_rd  = 1'b1;
    @(negedge sdram_clk);
    app_rd_valid = 1'b0;
    app_last_rd  = 1'b0;
    check_val("reenable_not_yet", 64'(app_req), 64'd0);
    @(negedge sdram_clk);
    check_val("reenable_latency", 64'(app_req), 64'd1);
    expect_grant(1);
    serve(1'b1);

    // ---- Orphan beats set a sticky flag ----
    rq_req = 2'b00;
    do_reset();
    app_rd_valid = 1'b1;
    #1;
    check_val("orphan_rd_valid_quiet", 64'(rq_rd_valid), 64'd0);
    @(negedge sdram_clk);
    app_rd_valid = 1'b0;
    check_val("orphan_rd_flag", 64'(err_orphan), 64'd1);
    repeat (3) @(negedge sdram_clk);
    check_val("orphan_sticky", 64'(err_orphan), 64'd1);
    do_reset();
    check_val("orphan_cleared", 64'(err_orphan), 64'd0);
    app_wr_next_req = 1'b1;
    #1;
    check_val("orphan_wr_next_quiet", 64'(rq_wr_next), 64'd0);
    @(negedge sdram_clk);
    app_wr_next_req = 1'b0;
    check_val("orphan_wr_flag", 64'(err_orphan), 64'd1);

    // ---- Reset during REQ with two reads outstanding ----
    rq_req = 2'b00;
    do_reset();
    rq_wr_n = 2'b11;
    rq_req  = 2'b10;
    expect_grant(1); serve(1'b1);
    rq_req = 2'b01;
    expect_grant(0); serve(1'b1);
    rq_req = 2'b10;
    n = 0;
    while (app_req !== 1'b1 && n < 20) begin
      @(negedge sdram_clk);
      n++;
    end
    check_val("pre_rst_req", 64'(app_req), 64'd1);
    check_val("pre_rst_addr", 64'(app_req_addr), 64'h2000);
    sdram_rst = 1'b1;
    rq_req    = 2'b11;
    @(negedge sdram_clk);
    sdram_rst = 1'b0;
    check_val("rst_mid_req_drop", 64'(app_req), 64'd0);
    app_rd_valid = 1'b1;
    app_last_rd  = 1'b1;
    #1;
    check_val("rst_rd_fifo_empty", 64'(rq_rd_valid), 64'd0);
    @(negedge sdram_clk);
    app_rd_valid = 1'b0;
    app_last_rd  = 1'b0;
    check_val("rst_rd_fifo_orphan", 64'(err_orphan), 64'd1);
    gq.delete();
    expect_grant(0);
    serve(1'b1);
    expect_grant(1);
    serve(1'b1);

    repeat (2) @(negedge sdram_clk);
    if (gq.size() != 0) check_val("grants_left", 64'(gq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
